clk_gen_ctrl: RTL and testbench

Programmable, glitch-free divided-clock controller that sequences the clock-generation resource from a free-running system clock. It produces a divided clock `div_clk` and an aligned one-cycle `tick` strobe. It accepts divide-ratio changes through a valid/ready handshake and applies them only on period boundaries. Start/stop requests are honoured without runt pulses. It sits between the control registers and any logic consuming the generated clock or clock-enable.

---
 rtl/clk_gen_pkg.sv | 5 +
 rtl/clk_gen_ctrl.sv | 60 ++++++
 tb/tb_clk_gen_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared state encodings and default widths for clk_gen_ctrl
package clk_gen_pkg;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {STOP = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
endpackage

// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: glitch-free programmable divided clock with tick strobe and handshaked ratio updates
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEF_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic             busy
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, act_half, pend_half;
  logic pend_vld, end_ph, xfer, cfg_ok, to_stop, rise, direct, apply;
  assign cfg_ready = !pend_vld;
  assign busy = state != STOP;
  assign end_ph = cnt == act_half - CNT_W'(1);
  always_ff @(posedge clk)
    if (rst) state <= STOP;
    else state <= state_nx;
  always_comb
    state_nx = (state == STOP) ? (run ? HIGH : STOP)
             : (state == HIGH) ? (end_ph ? (run ? LOW : STOP) : HIGH)
             : (!run ? STOP : end_ph ? HIGH : LOW);
  // a config arriving on the edge that enters STOP has no later boundary to wait for, so it lands directly
  always_comb begin
    xfer = cfg_valid && cfg_ready;
    cfg_ok = xfer && cfg_half != '0;
    to_stop = state != STOP && state_nx == STOP;
    rise = state == LOW && state_nx == HIGH;
    direct = cfg_ok && (state == STOP || to_stop);
    apply = pend_vld && (to_stop || rise);
    cnt_nx = (state_nx == state && state != STOP) ? cnt + CNT_W'(1) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      act_half <= CNT_W'(DEF_HALF);
      pend_half <= CNT_W'(DEF_HALF);
      pend_vld <= 1'b0;
      div_clk <= 1'b0;
      tick <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      act_half <= direct ? cfg_half : apply ? pend_half : act_half;
      pend_half <= (cfg_ok && !direct) ? cfg_half : pend_half;
      pend_vld <= (cfg_ok && !direct) || (pend_vld && !apply);
      div_clk <= state_nx == HIGH;
      tick <= state_nx == HIGH && state != HIGH;
      cfg_err <= xfer && cfg_half == '0;
    end
endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb_clk_gen_ctrl: directed self-checking bench for clk_gen_ctrl
`timescale 1ns/1ps
module tb_clk_gen_ctrl;
  logic clk = 0, rst = 1, run = 0, cfg_valid = 0;
  logic [7:0] cfg_half = 0;
  logic cfg_ready, cfg_err, div_clk, tick, busy;
  int checks = 0, failures = 0;

  clk_gen_ctrl #(.CNT_W(8), .DEF_HALF(2)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; run = 0; cfg_valid = 0;
    cycle(); cycle();
    rst = 0;
    checks += 5;
    if (div_clk !== 1'b0) begin failures++; $display("FAIL reset_div got=%b exp=0", div_clk); end
    if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_default_run();
    logic [7:0] ed = 8'b1100_1100, et = 8'b1000_1000;
    run = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks += 2;
      if (div_clk !== ed[7-i]) begin failures++; $display("FAIL def_div[%0d] got=%b exp=%b", i, div_clk, ed[7-i]); end
      if (tick !== et[7-i]) begin failures++; $display("FAIL def_tick[%0d] got=%b exp=%b", i, tick, et[7-i]); end
    end
  endtask

  task automatic test_cfg_change();
    logic [8:0] ed = 9'b001110001, et = 9'b001000001, er = 9'b001111111;
    cycle();
    checks += 2;
    if (tick !== 1'b1) begin failures++; $display("FAIL chg_tick0 got=%b exp=1", tick); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL chg_ready0 got=%b exp=1", cfg_ready); end
    cfg_valid = 1; cfg_half = 3;
    cycle();
    cfg_valid = 0;
    checks += 2;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL chg_ready1 got=%b exp=0", cfg_ready); end
    if (div_clk !== 1'b1) begin failures++; $display("FAIL chg_div1 got=%b exp=1", div_clk); end
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks += 3;
      if (div_clk !== ed[8-i]) begin failures++; $display("FAIL chg_div[%0d] got=%b exp=%b", i, div_clk, ed[8-i]); end
      if (tick !== et[8-i]) begin failures++; $display("FAIL chg_tick[%0d] got=%b exp=%b", i, tick, et[8-i]); end
      if (cfg_ready !== er[8-i]) begin failures++; $display("FAIL chg_ready[%0d] got=%b exp=%b", i, cfg_ready, er[8-i]); end
    end
  endtask

  task automatic test_stop_low();
    cycle(); cycle(); cycle();
    checks++;
    if (div_clk !== 1'b0) begin failures++; $display("FAIL slow_inlow got=%b exp=0", div_clk); end
    run = 0;
    cycle();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL slow_busy got=%b exp=0", busy); end
    if (div_clk !== 1'b0) begin failures++; $display("FAIL slow_div got=%b exp=0", div_clk); end
    cycle();
    checks++;
    if (div_clk !== 1'b0) begin failures++; $display("FAIL slow_div2 got=%b exp=0", div_clk); end
    run = 1;
    cycle();
    checks += 3;
    if (div_clk !== 1'b1) begin failures++; $display("FAIL slow_restart_div got=%b exp=1", div_clk); end
    if (tick !== 1'b1) begin failures++; $display("FAIL slow_restart_tick got=%b exp=1", tick); end
    if (busy !== 1'b1) begin failures++; $display("FAIL slow_restart_busy got=%b exp=1", busy); end
  endtask

  task automatic test_stop_high();
    run = 0;
    cycle(); cycle(); cycle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL shigh_stop3 got=%b exp=0", busy); end
    cfg_valid = 1; cfg_half = 4;
    cycle();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL shigh_ready got=%b exp=1", cfg_ready); end
    run = 1;
    cycle();
    run = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks += 2;
      if (div_clk !== 1'b1) begin failures++; $display("FAIL shigh_div[%0d] got=%b exp=1", i, div_clk); end
      if (busy !== 1'b1) begin failures++; $display("FAIL shigh_busy[%0d] got=%b exp=1", i, busy); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks += 2;
      if (div_clk !== 1'b0) begin failures++; $display("FAIL shigh_end_div[%0d] got=%b exp=0", i, div_clk); end
      if (busy !== 1'b0) begin failures++; $display("FAIL shigh_end_busy[%0d] got=%b exp=0", i, busy); end
    end
  endtask

  task automatic test_cfg_zero();
    logic [5:0] ed = 6'b100001, et = 6'b000001;
    cfg_valid = 1; cfg_half = 0;
    cycle();
    cfg_valid = 0;
    checks += 2;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL zstop_err got=%b exp=1", cfg_err); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zstop_ready got=%b exp=1", cfg_ready); end
    cycle();
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL zstop_err_clr got=%b exp=0", cfg_err); end
    run = 1;
    cycle();
    cfg_valid = 1; cfg_half = 0;
    cycle();
    cfg_valid = 0;
    checks += 2;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL zrun_err got=%b exp=1", cfg_err); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zrun_ready got=%b exp=1", cfg_ready); end
    cycle();
    checks += 2;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL zrun_err_clr got=%b exp=0", cfg_err); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zrun_ready2 got=%b exp=1", cfg_ready); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks += 2;
      if (div_clk !== ed[5-i]) begin failures++; $display("FAIL zrun_div[%0d] got=%b exp=%b", i, div_clk, ed[5-i]); end
      if (tick !== et[5-i]) begin failures++; $display("FAIL zrun_tick[%0d] got=%b exp=%b", i, tick, et[5-i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ed = 5'b11001, et = 5'b10001;
    cfg_valid = 1; cfg_half = 7;
    cycle();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rmid_pend got=%b exp=0", cfg_ready); end
    rst = 1;
    cycle();
    rst = 0;
    checks += 4;
    if (div_clk !== 1'b0) begin failures++; $display("FAIL rmid_div got=%b exp=0", div_clk); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", cfg_ready); end
    if (tick !== 1'b0) begin failures++; $display("FAIL rmid_tick got=%b exp=0", tick); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks += 2;
      if (div_clk !== ed[4-i]) begin failures++; $display("FAIL rmid_div[%0d] got=%b exp=%b", i, div_clk, ed[4-i]); end
      if (tick !== et[4-i]) begin failures++; $display("FAIL rmid_tick[%0d] got=%b exp=%b", i, tick, et[4-i]); end
    end
  endtask

  task automatic test_back_to_back();
    cycle(); cycle();
    checks++;
    if (div_clk !== 1'b0) begin failures++; $display("FAIL b2b_inlow got=%b exp=0", div_clk); end
    run = 0; cfg_valid = 1; cfg_half = 5;
    cycle();
    cfg_valid = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", cfg_ready); end
    run = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) run = 0;
      checks++;
      if (div_clk !== (i < 5)) begin failures++; $display("FAIL b2b_div[%0d] got=%b exp=%b", i, div_clk, i < 5); end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_change();
    test_stop_low();
    test_stop_high();
    test_cfg_zero();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
